// File: rtl/onehot_encoder_4to2.sv
// Registered 4-to-2 one-hot encoder with non-one-hot flagging, saturating error count and an output FIFO.
// Latency: one cycle from accept to buffer head; backpressure: in_ready = !full, so no word is ever dropped.
module onehot_encoder_4to2 #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    input  logic             y4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [1:0]       r_rst_sync;
    logic [2:0]       r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_cnt;
    logic [2:0]       r_last;
    logic [CNT_W-1:0] r_err_cnt;

    logic       w_run;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_code;
    logic       w_err;
    logic [2:0] w_head;

    // Reset asserts asynchronously but releases on a clock edge, so the
    // handshake only opens once the local reset has cleanly deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    always_comb begin
        w_code = 2'b00;
        if (y4) begin
            w_code = 2'b11;
        end else if (y3) begin
            w_code = 2'b10;
        end else if (y2) begin
            w_code = 2'b01;
        end
    end

    always_comb begin
        w_err = 1'b1;
        case ({y4, y3, y2, y1})
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_err = 1'b0;
            default:                            w_err = 1'b1;
        endcase
    end

    assign w_full    = (r_cnt == OW'(DEPTH));
    assign in_ready  = w_run & ~w_full;
    assign out_valid = (r_cnt != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_code, w_err};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + OW'(1);
                2'b01:   r_cnt <= r_cnt - OW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    // With the buffer empty the outputs keep showing the last word popped.
    assign w_head       = out_valid ? r_mem[r_rd_ptr] : r_last;
    assign {a, b, err}  = w_head;
    assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_onehot_encoder_4to2.sv
// Bench for onehot_encoder_4to2: directed and random traffic against a queue-based reference model.
module tb_onehot_encoder_4to2;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             y1, y2, y3, y4;
    logic             out_valid;
    logic             out_ready;
    logic             a, b, err;
    logic [CNT_W-1:0] err_cnt;

    int n_chk;
    int n_fail;
    int exp_cnt;

    onehot_encoder_4to2 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference: code is the index of the highest set bit (w[0] = y1), error unless exactly one bit set.
    function automatic logic [2:0] ref_enc(input logic [3:0] w);
        int hi;
        int n;
        logic [1:0] c;
        hi = 0;
        n  = 0;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
                hi = i;
                n++;
            end
        end
        c = 2'(hi);
        return {c, (n != 1)};
    endfunction

    function automatic int next_cnt(input int cur, input logic [2:0] enc);
        if (enc[0] && cur < CMAX) return cur + 1;
        return cur;
    endfunction

    task automatic tick(input logic iv, input logic [3:0] w, input logic ordy,
                        output logic acc, output logic popd, output logic [2:0] head);
        in_valid  = iv;
        y1        = w[0];
        y2        = w[1];
        y3        = w[2];
        y4        = w[3];
        out_ready = ordy;
        @(negedge clk);
        acc  = in_valid & in_ready;
        popd = out_valid & out_ready;
        head = {a, b, err};
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(output bit ok);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        wait_ready(ok);
    endtask

    task automatic test_reset();
        bit ok;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        {y4, y3, y2, y1} = 4'b0000;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if ({a, b, err} !== 3'b000) begin n_fail++; $display("FAIL reset_outputs: got %b want 000", {a, b, err}); end
        n_chk++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        rst_n   = 1'b1;
        exp_cnt = 0;
        wait_ready(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL reset_release: in_ready got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_empty: got %b want 0", out_valid); end
    endtask

    task automatic run_words(input string name, input logic [3:0] w);
        logic acc, pd;
        logic [2:0] h;
        logic [2:0] e;
        e = ref_enc(w);
        tick(1'b1, w, 1'b1, acc, pd, h);
        if (acc) exp_cnt = next_cnt(exp_cnt, e);
        n_chk++; if (acc !== 1'b1) begin n_fail++; $display("FAIL %s_accept: got %b want 1", name, acc); end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency: out_valid got %b want 1", name, out_valid); end
        n_chk++; if ({a, b, err} !== e) begin n_fail++; $display("FAIL %s_enc w=%b: got %b want %b", name, w, {a, b, err}, e); end
        n_chk++; if (int'(err_cnt) !== exp_cnt) begin n_fail++; $display("FAIL %s_err_cnt: got %0d want %0d", name, err_cnt, exp_cnt); end
        tick(1'b0, 4'b0000, 1'b1, acc, pd, h);
        n_chk++; if (pd !== 1'b1 || h !== e) begin n_fail++; $display("FAIL %s_pop: got pop=%b head=%b want pop=1 head=%b", name, pd, h, e); end
        n_chk++; if (out_valid !== 1'b0 || {a, b, err} !== e) begin n_fail++; $display("FAIL %s_hold: got v=%b out=%b want v=0 out=%b", name, out_valid, {a, b, err}, e); end
    endtask

    task automatic test_singles();
        logic [3:0] words [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) run_words("single", words[i]);
        n_chk++; if (err_cnt !== '0) begin n_fail++; $display("FAIL singles_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_errors();
        logic [3:0] words [3] = '{4'b0000, 4'b1010, 4'b0111};
        for (int i = 0; i < 3; i++) run_words("multihot", words[i]);
        n_chk++; if (int'(err_cnt) !== 3) begin n_fail++; $display("FAIL errors_err_cnt: got %0d want 3", err_cnt); end
    endtask

    task automatic test_saturation();
        bit ok;
        logic acc, pd;
        logic [2:0] h;
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        do_reset(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL sat_reset: in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 4'b0000, 1'b1, acc, pd, h);
            n_chk++; if (int'(err_cnt) !== sat_exp[i]) begin n_fail++; $display("FAIL sat_err_cnt[%0d]: got %0d want %0d", i, err_cnt, sat_exp[i]); end
        end
        exp_cnt = CMAX;
        tick(1'b0, 4'b0000, 1'b1, acc, pd, h);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic acc, pd;
        logic [2:0] h;
        logic [3:0] w0, w1, w2;
        w0 = 4'b0001;
        w1 = 4'b1000;
        w2 = 4'b0100;
        tick(1'b1, w0, 1'b0, acc, pd, h);
        n_chk++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_acc0: got %b want 1", acc); end
        tick(1'b1, w1, 1'b0, acc, pd, h);
        n_chk++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_acc1: got %b want 1", acc); end
        tick(1'b1, w2, 1'b0, acc, pd, h);
        n_chk++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_full_refuse: got %b want 0", acc); end
        tick(1'b1, w2, 1'b0, acc, pd, h);
        n_chk++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold: got %b want 0", acc); end
        tick(1'b1, w2, 1'b1, acc, pd, h);
        n_chk++; if (acc !== 1'b0 || pd !== 1'b1 || h !== ref_enc(w0)) begin n_fail++; $display("FAIL bp_pop0: got acc=%b pop=%b head=%b want acc=0 pop=1 head=%b", acc, pd, h, ref_enc(w0)); end
        tick(1'b1, w2, 1'b1, acc, pd, h);
        n_chk++; if (acc !== 1'b1 || pd !== 1'b1 || h !== ref_enc(w1)) begin n_fail++; $display("FAIL bp_pop1: got acc=%b pop=%b head=%b want acc=1 pop=1 head=%b", acc, pd, h, ref_enc(w1)); end
        tick(1'b0, 4'b0000, 1'b1, acc, pd, h);
        n_chk++; if (pd !== 1'b1 || h !== ref_enc(w2)) begin n_fail++; $display("FAIL bp_pop2: got pop=%b head=%b want pop=1 head=%b", pd, h, ref_enc(w2)); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        logic acc, pd, iv, ordy;
        logic [2:0] h;
        logic [3:0] one;
        logic [3:0] cur;
        logic [2:0] exp_q [$];
        int sent, rcvd, occ;
        one  = 4'b0001;
        cur  = one << $urandom_range(0, 3);
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
            iv   = (sent < 20);
            ordy = 1'($urandom_range(0, 1));
            occ  = exp_q.size();
            tick(iv, cur, ordy, acc, pd, h);
            n_chk++; if (acc !== (iv && occ < DEPTH)) begin n_fail++; $display("FAIL stream_in_ready cyc=%0d: got acc=%b want %b (occ %0d)", cyc, acc, (iv && occ < DEPTH), occ); end
            n_chk++; if (pd !== (ordy && occ > 0)) begin n_fail++; $display("FAIL stream_out_valid cyc=%0d: got pop=%b want %b (occ %0d)", cyc, pd, (ordy && occ > 0), occ); end
            if (pd && exp_q.size() > 0) begin
                n_chk++; if (h !== exp_q[0]) begin n_fail++; $display("FAIL stream_data #%0d: got %b want %b", rcvd, h, exp_q[0]); end
                void'(exp_q.pop_front());
                rcvd++;
            end
            if (acc) begin
                exp_q.push_back(ref_enc(cur));
                sent++;
                cur = one << $urandom_range(0, 3);
            end
        end
        n_chk++; if (rcvd != 20) begin n_fail++; $display("FAIL stream_count: got %0d words want 20", rcvd); end
        n_chk++; if (int'(err_cnt) !== exp_cnt) begin n_fail++; $display("FAIL stream_err_cnt: got %0d want %0d", err_cnt, exp_cnt); end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        logic acc, pd;
        logic [2:0] h;
        do_reset(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL mid_prereset: in_ready got %b want 1", in_ready); end
        tick(1'b1, 4'b0000, 1'b0, acc, pd, h);
        tick(1'b1, 4'b0000, 1'b0, acc, pd, h);
        n_chk++; if (int'(err_cnt) !== 2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_setup: got cnt=%0d v=%b rdy=%b want cnt=2 v=1 rdy=0", err_cnt, out_valid, in_ready); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_chk++; if (int'(err_cnt) !== 0) begin n_fail++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
        n_chk++; if ({a, b, err} !== 3'b000) begin n_fail++; $display("FAIL mid_outputs: got %b want 000", {a, b, err}); end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        wait_ready(ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL mid_release: in_ready got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: out_valid got %b want 0", out_valid); end
        tick(1'b1, 4'b0100, 1'b1, acc, pd, h);
        n_chk++; if (acc !== 1'b1 || out_valid !== 1'b1 || {a, b, err} !== 3'b100) begin n_fail++; $display("FAIL mid_first_word: got acc=%b v=%b out=%b want acc=1 v=1 out=100", acc, out_valid, {a, b, err}); end
        tick(1'b0, 4'b0000, 1'b1, acc, pd, h);
        n_chk++; if (pd !== 1'b1 || h !== 3'b100 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drain: got pop=%b head=%b v=%b want pop=1 head=100 v=0", pd, h, out_valid); end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        exp_cnt = 0;
        test_reset();
        test_singles();
        test_errors();
        test_saturation();
        test_backpressure();
        test_stream();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_4to2.md
Name: onehot_encoder_4to2

Overview:
- Registered 4-to-2 encoder: the inverse of the team's 2-to-4 decoder.
- Accepts decoder-style one-hot words (y1..y4) over a valid/ready handshake and returns the encoded pair (a, b).
- Flags words that are not one-hot, counts errors, and buffers results in a small output FIFO so back-pressure never drops data.
- Sits downstream of the decoder in loop-back benches and on datapaths that re-encode select lines.

Parameters:
- DEPTH, 2, output buffer entries; power of two, range 2..16.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- y1  input  1  one-hot bit 0.
- y2  input  1  one-hot bit 1.
- y3  input  1  one-hot bit 2.
- y4  input  1  one-hot bit 3.
- out_valid  output  1  head of buffer valid.
- out_ready  input  1  consumer accepts head this cycle.
- a  output  1  encoded MSB.
- b  output  1  encoded LSB.
- err  output  1  head word was not one-hot.
- err_cnt  output  CNT_W  saturating count of accepted non-one-hot words.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - buffer emptied; in_ready=1 while rst_n=1 and buffer not full.
  - out_valid=0, a=0, b=0, err=0, err_cnt=0.
  - Asserting rst_n=0 mid-operation discards all buffered words immediately.
- Accept: a word is taken when in_valid & in_ready at a clk edge.
  - in_ready = !full, independent of in_valid.
- Encoding {a,b}:
  - y1 only → 00; y2 only → 01; y3 only → 10; y4 only → 11.
  - Multi-hot: priority to the highest-index set bit (y4 > y3 > y2 > y1), err=1.
  - All-zero: {a,b}=00, err=1.
  - Exactly one bit set: err=0.
- Latency: a word accepted at edge N appears at the head at edge N+1 when the buffer was empty (out_valid rises that cycle). No combinational in→out path.
- Output: a, b and err reflect the buffer head while out_valid=1, and hold their last popped value when out_valid=0. The head pops on out_valid & out_ready.
- Buffer: circular FIFO with DEPTH entries; read/write pointers wrap modulo DEPTH; occupancy counter is 0..DEPTH.
  - Full: in_ready=0; in_valid is ignored and the word is not counted.
  - Empty: out_valid=0; out_ready is ignored.
  - Simultaneous push and pop when full: the pop happens; the push is refused because in_ready was 0 that cycle.
  - Simultaneous push and pop when non-empty and not full: occupancy unchanged, order preserved.
- err_cnt increments by 1 on each accepted word with err=1, and saturates at 2^CNT_W-1 with no wrap.
  - It is not cleared by reading; only reset clears it.
- Held inputs: while in_valid=1 and in_ready=0, the source holds y1..y4 stable. The block does not check this.

Test Plan:
- Reset, then push y1..y4 singly (1000, 0100, 0010, 0001 as y1y2y3y4), out_ready=1 → {a,b}=00, 01, 10, 11 one cycle after each accept; err=0; err_cnt=0.
- Push 0000, then y2+y4, then y1+y2+y3 → {a,b}=00 err=1, 11 err=1, 10 err=1; err_cnt=3.
- out_ready=0 with continuous in_valid, DEPTH=2 → two words accepted, in_ready=0 from the third cycle, third word held. Raise out_ready → heads pop in order, the third word is accepted the cycle after the first pop, no loss or duplication.
- Steady streaming of 20 random one-hot words with out_ready toggling pseudo-randomly → output sequence equals the decoder inverse of the input sequence; occupancy never exceeds DEPTH; pointer wrap is exercised.
- CNT_W=2, push 5 all-zero words → err_cnt reads 1, 2, 3, 3, 3.
- Buffer holding 2 words and err_cnt=2, drive rst_n=0 between edges → out_valid=0, err_cnt=0, a=b=err=0 immediately. After release, the first pushed word (0010) emerges as {a,b}=10 with no stale data.
